// File: rtl/mnist_argmax_out.sv
// mnist_argmax_out: argmax output stage behind the layer-2 array.
// It scans the class scores one per cycle after stop2 rises and keeps the
// signed maximum. The result is exposed on a PicoRV32 peripheral port, and a
// one-cycle irq is raised when the result becomes available.
// Optional build macro: ARGMAX_SCORE_READ_EN adds live score reads at 0x10+4*i.
//
// state | meaning
// IDLE  | waiting for a stop2 rising edge
// SCAN  | comparing scores[idx] against the running best, one per cycle
// DONE  | result held, irq pulsed on entry, waiting for a CLEAR write
module mnist_argmax_out #(
  parameter int          NUM_CLASSES = 10,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stop2,
  input  logic [DATA_W*NUM_CLASSES-1:0] scores,
  input  logic                          mem_valid,
  input  logic [31:0]                   mem_addr,
  input  logic [3:0]                    mem_wstrb,
  input  logic [31:0]                   mem_wdata,
  output logic                          mem_ready,
  output logic [31:0]                   mem_rdata,
  output logic                          result_valid,
  output logic [3:0]                    result_idx,
  output logic                          irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t              state, state_next;
  logic                stop2_q;
  logic [3:0]          idx;
  logic [DATA_W-1:0]   best;
  logic [3:0]          best_idx;
  logic                irq_sent;
  logic                start;
  logic                hit;
  logic                clear_wr;
  logic [DATA_W-1:0]   cur_score;
  logic [31:0]         rd_val;
  logic                unused_wdata;

  // Scores may be narrower or wider than the bus; the cast sign-extends or truncates.
  function automatic logic [31:0] to_bus(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  assign unused_wdata = ^mem_wdata;
  assign start        = stop2 & ~stop2_q;
  assign hit          = mem_valid & (mem_addr[31:8] == BASE_ADDR[31:8]) & ~mem_ready;
  assign clear_wr     = hit & (mem_wstrb != 4'd0) & (mem_addr[7:0] == 8'h0C) & (state == DONE);
  assign cur_score    = scores[DATA_W*idx +: DATA_W];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and result outputs.
  always_comb begin
    state_next   = state;
    result_valid = 1'b0;
    result_idx   = 4'd0;
    irq          = 1'b0;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: if (idx == LAST_IDX) state_next = DONE;
      DONE: begin
        result_valid = 1'b1;
        result_idx   = best_idx;
        irq          = ~irq_sent;
        if (clear_wr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge detect, scan datapath and irq-once tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      stop2_q  <= 1'b0;
      idx      <= 4'd0;
      best     <= '0;
      best_idx <= 4'd0;
      irq_sent <= 1'b0;
    end else begin
      stop2_q  <= stop2;
      irq_sent <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            best     <= scores[DATA_W-1:0];
            best_idx <= 4'd0;
            idx      <= 4'd1;
          end
        end
        SCAN: begin
          // Strict compare: a tie keeps the earlier (lower) index.
          if ($signed(cur_score) > $signed(best)) begin
            best     <= cur_score;
            best_idx <= idx;
          end
          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Register-map read mux.
  always_comb begin
    rd_val = 32'd0;
    case (mem_addr[7:0])
      8'h00: rd_val = {30'd0, (state == SCAN), (state == DONE)};
      8'h04: if (state == DONE) rd_val = {28'd0, best_idx};
      8'h08: if (state == DONE) rd_val = to_bus(best);
      default: begin
`ifdef ARGMAX_SCORE_READ_EN
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (mem_addr[7:0] == 8'(16 + 4*i)) rd_val = to_bus(scores[DATA_W*i +: DATA_W]);
        end
`endif
      end
    endcase
  end

  // Bus response: one-cycle ready per hit, rdata zero outside the ready cycle and on writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_ready <= hit;
      mem_rdata <= (hit && mem_wstrb == 4'd0) ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_mnist_argmax_out.sv
// Testbench for mnist_argmax_out: directed vectors with a scoreboard.
// Bus reads and scan results are queued as expectations; a negedge monitor
// pops and compares them whenever mem_ready pulses or result_valid rises.
module tb_mnist_argmax_out;
  localparam int N  = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          stop2;
  logic [DW*N-1:0] scores;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          result_valid;
  logic [3:0]    result_idx;
  logic          irq;

  mnist_argmax_out dut (
    .clk(clk), .reset(reset), .stop2(stop2), .scores(scores),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .result_valid(result_valid), .result_idx(result_idx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int irq_cnt = 0;
  int res_cnt = 0;
  int t0 = 0;
  int irq0 = 0;
  logic prev_ready = 1'b0;
  logic prev_rv = 1'b0;
  logic [31:0] rd_q[$];
  string       nm_q[$];
  logic [3:0]  res_q[$];
  int sc[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares bus responses and results against queued expectations.
  always @(negedge clk) begin
    if (mem_ready) begin
      ready_cnt++;
      check("ready width", 32'(prev_ready), 32'd0);
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected mem_ready: rdata %0h with nothing expected", mem_rdata);
      end else begin
        check(nm_q.pop_front(), mem_rdata, rd_q.pop_front());
      end
    end
    if (irq) irq_cnt++;
    if (result_valid && !prev_rv) begin
      res_cnt++;
      check("irq on done entry", 32'(irq), 32'd1);
      if (res_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected result: idx %0d with nothing expected", result_idx);
      end else begin
        check("result_idx", 32'(result_idx), 32'(res_q.pop_front()));
      end
    end
    prev_ready = mem_ready;
    prev_rv    = result_valid;
  end

  task automatic load_scores();
    for (int i = 0; i < N; i++) scores[DW*i +: DW] = 32'(sc[i]);
  endtask

  task automatic basic_scores();
    sc = '{5, -3, 12, 7, 0, 1, 2, 3, 4, -9};
    load_scores();
  endtask

  // Holds mem_valid for ncyc edges; exp_pulses ready pulses are expected, each carrying exp_rd.
  task automatic bus_hold(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                          input int ncyc, input logic [31:0] exp_rd, input int exp_pulses);
    int p0;
    p0 = ready_cnt;
    for (int i = 0; i < exp_pulses; i++) begin
      rd_q.push_back(exp_rd);
      nm_q.push_back(name);
    end
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = 32'hA5A5_0000;
    mem_valid = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check({name, " pulses"}, 32'(ready_cnt - p0), 32'(exp_pulses));
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp_rd);
    bus_hold(name, addr, 4'd0, 1, exp_rd, 1);
  endtask

  task automatic start_scan(input logic [3:0] exp_idx);
    res_q.push_back(exp_idx);
    t0    = cyc;
    irq0  = irq_cnt;
    stop2 = 1'b1;
  endtask

  task automatic wait_result(input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({name, " latency"}, 32'(lat), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check({name, " irq count"}, 32'(irq_cnt - irq0), 32'd1);
  endtask

  task automatic clear_and_drop();
    bus_hold("clear", 32'h0300_000C, 4'hF, 1, 32'd0, 1);
    stop2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    reset = 1'b1; stop2 = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0;
    mem_wstrb = 4'd0; mem_wdata = 32'd0;
    basic_scores();
    repeat (3) @(posedge clk);
    #1;
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result_idx", 32'(result_idx), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset mem_ready", 32'(mem_ready), 32'd0);
    check("reset mem_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    rd("status idle", 32'h0300_0000, 32'd0);

    // Basic max at index 2.
    start_scan(4'd2);
    wait_result("basic");
    rd("maxscore basic", 32'h0300_0008, 32'd12);
    rd("result basic", 32'h0300_0004, 32'd2);

    // Held request: a hit only occurs while ready is low, so edges 1 and 3 respond.
    bus_hold("status held", 32'h0300_0000, 4'd0, 4, 32'd1, 2);
    bus_hold("other slave", 32'h0400_0000, 4'd0, 1, 32'd0, 0);
    bus_hold("ro write", 32'h0300_0004, 4'hF, 1, 32'd0, 1);
    rd("result after ro write", 32'h0300_0004, 32'd2);
    rd("unmapped", 32'h0300_0040, 32'd0);

    // Clear with stop2 still high: back to IDLE, no rescan.
    bus_hold("clear", 32'h0300_000C, 4'hF, 1, 32'd0, 1);
    repeat (3) @(posedge clk);
    #1;
    rd("status after clear", 32'h0300_0000, 32'd0);
    check("no rescan", 32'(result_valid), 32'd0);
    stop2 = 1'b0;
    @(posedge clk);
    #1;

    // Negatives with a tie: lower index wins.
    for (int i = 0; i < N; i++) sc[i] = -100;
    sc[4] = -1;
    sc[7] = -1;
    load_scores();
    start_scan(4'd4);
    wait_result("tie");
    rd("maxscore tie", 32'h0300_0008, 32'hFFFF_FFFF);
    rd("result tie", 32'h0300_0004, 32'd4);
    clear_and_drop();

    // Re-arm with a new maximum at the last class.
    basic_scores();
    sc[9] = 99;
    load_scores();
    start_scan(4'd9);
    wait_result("rearm");
    rd("maxscore rearm", 32'h0300_0008, 32'd99);
    clear_and_drop();

    // CLEAR and a stop2 glitch during SCAN must not disturb the scan.
    basic_scores();
    start_scan(4'd2);
    @(posedge clk);
    #1;
    bus_hold("clear in scan", 32'h0300_000C, 4'hF, 1, 32'd0, 1);
    stop2 = 1'b0;
    @(posedge clk);
    #1;
    stop2 = 1'b1;
    @(posedge clk);
    #1;
    rd("status scan", 32'h0300_0000, 32'd2);
    wait_result("midscan");
    clear_and_drop();

    // Reset during SCAN cycle 3 discards the partial result.
    r0 = res_cnt;
    stop2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    stop2 = 1'b0;
    @(posedge clk);
    #1;
    check("midreset result_valid", 32'(result_valid), 32'd0);
    check("midreset result_idx", 32'(result_idx), 32'd0);
    check("midreset irq", 32'(irq), 32'd0);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("midreset no result", 32'(res_cnt - r0), 32'd0);
    rd("status after reset", 32'h0300_0000, 32'd0);

    // Live score read (scores[3] = 7) only with the optional feature.
`ifdef ARGMAX_SCORE_READ_EN
    rd("score3 read", 32'h0300_001C, 32'(sc[3]));
`else
    rd("score3 read", 32'h0300_001C, 32'd0);
`endif

    check("rd queue drained", 32'(rd_q.size()), 32'd0);
    check("res queue drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
